skid_register: RTL and testbench

//   Consumer-side counterpart to the general register. The general register

---
 rtl/skid_register.sv | 107 ++++++++++
 tb/tb_skid_register.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/skid_register.sv
// Two-entry skid buffer with a valid/ready handshake on both sides.
// in_ready is decoded from the state register only, so out_ready never reaches it combinationally.
module skid_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  skid_register_clock_in,
    input  logic                  skid_register_reset_in,
    input  logic                  skid_register_flush_in,
    input  logic [DATA_WIDTH-1:0] skid_register_in_data,
    input  logic                  skid_register_in_valid,
    output logic                  skid_register_in_ready,
    output logic [DATA_WIDTH-1:0] skid_register_out_data,
    output logic                  skid_register_out_valid,
    input  logic                  skid_register_out_ready,
    output logic [1:0]            skid_register_count_out
);

    // state    | meaning
    // ST_EMPTY | no entries held, out_valid low
    // ST_ONE   | main register holds the oldest entry
    // ST_TWO   | main and skid both full, producer stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;

    logic in_fire;
    logic out_fire;

    assign skid_register_in_ready  = (state_q != ST_TWO);
    assign skid_register_out_valid = (state_q != ST_EMPTY);
    assign skid_register_out_data  = main_q;

    assign in_fire  = skid_register_in_valid & skid_register_in_ready;
    assign out_fire = skid_register_out_valid & skid_register_out_ready;

    always_comb begin
        skid_register_count_out = 2'd0;
        case (state_q)
            ST_ONE:  skid_register_count_out = 2'd1;
            ST_TWO:  skid_register_count_out = 2'd2;
            default: skid_register_count_out = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        // Flush drops the state but leaves payload registers untouched;
        // a concurrent out_fire has already been seen by the consumer.
        if (skid_register_flush_in) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = skid_register_in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = skid_register_in_data;
                        state_d = ST_ONE;
                    end else if (in_fire) begin
                        skid_d  = skid_register_in_data;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge skid_register_clock_in or posedge skid_register_reset_in) begin
        if (skid_register_reset_in) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_skid_register.sv
// Self-checking bench for skid_register: a queue scoreboard tracks expected
// contents, each scenario task compares DUT outputs against it inline.
module tb_skid_register;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    int total;
    int bad;

    logic [31:0] sb[$];

    skid_register #(.DATA_WIDTH(32)) dut (
        .skid_register_clock_in  (clk),
        .skid_register_reset_in  (rst),
        .skid_register_flush_in  (flush),
        .skid_register_in_data   (in_data),
        .skid_register_in_valid  (in_valid),
        .skid_register_in_ready  (in_ready),
        .skid_register_out_data  (out_data),
        .skid_register_out_valid (out_valid),
        .skid_register_out_ready (out_ready),
        .skid_register_count_out (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of stimulus from a negedge, updates the scoreboard
    // at the rising edge, and returns on the following negedge.
    task automatic advance(input logic iv, input logic [31:0] id,
                           input logic ordy, input logic fl);
        logic ofire;
        logic ifire;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        ofire = (sb.size() != 0) && ordy;
        ifire = iv && (sb.size() < 2) && !fl;
        @(posedge clk);
        if (ofire) void'(sb.pop_front());
        if (fl) sb.delete();
        if (ifire) sb.push_back(id);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
            total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
            total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        advance(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        total++; if (out_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data got=%h exp=a5a50001", out_data); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        advance(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%0b exp=0", out_valid); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL single_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 16; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%0b exp=1", i, in_ready); end
            if (i > 0) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid i=%0d got=%0b exp=1", i, out_valid); end
                total++; if (out_data !== 32'(i - 1)) begin bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, out_data, 32'(i - 1)); end
            end
            advance(i < 16, 32'(i), 1'b1, 1'b0);
        end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_bp[3];
        int idx;
        logic hold33;
        exp_bp[0] = 32'h11; exp_bp[1] = 32'h22; exp_bp[2] = 32'h33;
        advance(1'b1, 32'h11, 1'b0, 1'b0);
        total++; if (count !== 2'd1) begin bad++; $display("FAIL bp_count1 got=%0d exp=1", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
        advance(1'b1, 32'h22, 1'b0, 1'b0);
        total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_count2 got=%0d exp=2", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%0b exp=0", in_ready); end
        total++; if (out_data !== 32'h11) begin bad++; $display("FAIL bp_head got=%h exp=11", out_data); end
        advance(1'b1, 32'h33, 1'b0, 1'b0);
        advance(1'b1, 32'h33, 1'b0, 1'b0);
        total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_hold_count got=%0d exp=2", count); end
        idx = 0;
        hold33 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid === 1'b1) begin
                total++;
                if (idx > 2 || out_data !== exp_bp[idx > 2 ? 2 : idx]) begin
                    bad++; $display("FAIL bp_order idx=%0d got=%h", idx, out_data);
                end
                idx++;
            end
            if (hold33 && sb.size() < 2) begin
                advance(1'b1, 32'h33, 1'b1, 1'b0);
                hold33 = 1'b0;
            end else begin
                advance(hold33, 32'h33, 1'b1, 1'b0);
            end
        end
        total++; if (idx !== 3) begin bad++; $display("FAIL bp_drained got=%0d exp=3", idx); end
    endtask

    task automatic test_flush();
        advance(1'b1, 32'h61, 1'b0, 1'b0);
        advance(1'b1, 32'h62, 1'b0, 1'b0);
        total++; if (count !== 2'd2) begin bad++; $display("FAIL flush_fill got=%0d exp=2", count); end
        advance(1'b1, 32'h44, 1'b0, 1'b1);
        total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
        repeat (3) begin
            advance(1'b0, 32'h0, 1'b1, 1'b0);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got_valid=%0b data=%h exp_valid=0", out_valid, out_data); end
        end
        advance(1'b1, 32'h77, 1'b0, 1'b0);
        total++; if (out_data !== 32'h77 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_outfire_seen got=%h/%0b exp=77/1", out_data, out_valid); end
        advance(1'b0, 32'h0, 1'b1, 1'b1);
        total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_outfire_count got=%0d exp=0", count); end
    endtask

    task automatic test_async_reset();
        advance(1'b1, 32'h91, 1'b0, 1'b0);
        advance(1'b1, 32'h92, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", out_data); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        advance(1'b1, 32'h55, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin bad++; $display("FAIL arst_fresh got=%h/%0b exp=55/1", out_data, out_valid); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL arst_fresh_count got=%0d exp=1", count); end
        advance(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            d    = $urandom;
            total++; if (out_valid !== (sb.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b", c, out_valid); end
            total++; if (in_ready !== (sb.size() < 2)) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b", c, in_ready); end
            total++; if (count !== 2'(sb.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, sb.size()); end
            if (sb.size() != 0) begin
                total++; if (out_data !== sb[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, sb[0]); end
            end
            advance(iv, d, ordy, fl);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
